// File: rtl/apb_intc_8.sv
`timescale 1ns/1ps
// apb_intc_8 - 8-source APB interrupt controller (bridge slot PSEL2).
//
// Each source passes through a two-flop synchronizer and a delay flop.
// Sources are captured into pending bits either as rising edges or as
// mirrored levels. Pending bits are masked and globally gated, and a fixed
// priority picks the winner (bit0 highest). irq_out/irq_id are registered.
//
// Ports:
//   pclk, presetn         APB clock, asynchronous active-low reset
//   psel, penable, pwrite APB control; zero wait states
//   paddr                 byte address, only paddr[3:0] decoded
//   pwdata / prdata       8-bit write / read data
//   pready, pslverr       transfer complete / error (error only with pready)
//   irq_src               raw interrupt inputs, bit0 = timer trigger_int
//   irq_out, irq_id       registered combined interrupt and winning index
module apb_intc_8 #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_SRC        = 8
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [7:0]                pwdata,
  input  logic [NUM_SRC-1:0]        irq_src,
  output logic [7:0]                prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic                      irq_out,
  output logic [2:0]                irq_id
);

  typedef enum logic [3:0] {
    REG_CTRL = 4'h0,
    REG_IER  = 4'h1,
    REG_ITR  = 4'h2,
    REG_IPR  = 4'h3,
    REG_IRAW = 4'h4,
    REG_IID  = 4'h5,
    REG_ISWR = 4'h6
  } reg_off_e;

  reg_off_e           off;
  logic               access;
  logic               err;
  logic               wr_en;
  logic               unused_addr;

  logic               gen;
  logic [NUM_SRC-1:0] ier;
  logic [NUM_SRC-1:0] itr;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pending_next;

  logic [NUM_SRC-1:0] sync_a;
  logic [NUM_SRC-1:0] sync;
  logic [NUM_SRC-1:0] sync_d;

  logic [NUM_SRC-1:0] edge_evt;
  logic [NUM_SRC-1:0] sw_set;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] to_edge;
  logic [NUM_SRC-1:0] edge_next;
  logic [NUM_SRC-1:0] active;
  logic [2:0]         id_next;

  assign off         = reg_off_e'(paddr[3:0]);
  assign unused_addr = ^paddr[APB_ADDR_WIDTH-1:4];

  // Gating with presetn drops pready the moment reset asserts mid-transfer.
  assign access  = psel & penable & presetn;
  assign pready  = access;
  assign err     = (paddr[3:0] >= 4'h7) ||
                   (pwrite && (off == REG_IRAW || off == REG_IID));
  assign pslverr = access & err;
  assign wr_en   = access & pwrite & ~err;

  always_comb begin
    prdata = '0;
    if (access) begin
      case (off)
        REG_CTRL: prdata = {7'b0, gen};
        REG_IER:  prdata = 8'(ier);
        REG_ITR:  prdata = 8'(itr);
        REG_IPR:  prdata = 8'(pending);
        REG_IRAW: prdata = 8'(sync);
        REG_IID:  prdata = {irq_out, 4'b0, irq_id};
        default:  prdata = '0;
      endcase
    end
  end

  // Pending update. Edge bits: set (hw edge or ISWR) beats W1C beats hold.
  // Level bits mirror the synchronized input. A bit switched level->edge is
  // cleared outright; sync_d already tracks the input, so no false edge.
  always_comb begin
    edge_evt     = sync & ~sync_d;
    sw_set       = (wr_en && off == REG_ISWR) ? pwdata[NUM_SRC-1:0] : '0;
    w1c          = (wr_en && off == REG_IPR)  ? pwdata[NUM_SRC-1:0] : '0;
    to_edge      = (wr_en && off == REG_ITR)  ? (pwdata[NUM_SRC-1:0] & ~itr) : '0;
    edge_next    = ((edge_evt | sw_set) & itr) | (pending & ~w1c);
    pending_next = ((itr & edge_next) | (~itr & sync)) & ~to_edge;
  end

  always_comb begin
    active  = pending & ier & {NUM_SRC{gen}};
    id_next = '0;
    // Scan high to low so the lowest active index is the final assignment.
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (active[NUM_SRC-1-i]) id_next = 3'(NUM_SRC - 1 - i);
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync_a  <= '0;
      sync    <= '0;
      sync_d  <= '0;
      gen     <= 1'b0;
      ier     <= '0;
      itr     <= '0;
      pending <= '0;
      irq_out <= 1'b0;
      irq_id  <= '0;
    end else begin
      sync_a  <= irq_src;
      sync    <= sync_a;
      sync_d  <= sync;
      pending <= pending_next;
      irq_out <= |active;
      irq_id  <= id_next;
      if (wr_en) begin
        case (off)
          REG_CTRL: gen <= pwdata[0];
          REG_IER:  ier <= pwdata[NUM_SRC-1:0];
          REG_ITR:  itr <= pwdata[NUM_SRC-1:0];
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_intc_8.sv
`timescale 1ns/1ps
module tb_apb_intc_8;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [7:0]  pwdata;
  logic [7:0]  irq_src;
  logic [7:0]  prdata;
  logic        pready;
  logic        pslverr;
  logic        irq_out;
  logic [2:0]  irq_id;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  apb_intc_8 #(.APB_ADDR_WIDTH(12), .NUM_SRC(8)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .irq_src (irq_src),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .irq_out (irq_out),
    .irq_id  (irq_id)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t exceeded bound", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
    end else begin
      e.tag = "sb_empty";
      e.exp = ~obs;
    end
    check(e.tag, obs, e.exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [7:0] data, input logic exp_err);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = {8'h02, addr}; pwdata = data;
    sb_push($sformatf("wr%0h_rdy", addr), 1);
    sb_push($sformatf("wr%0h_err", addr), 32'(exp_err));
    @(posedge pclk); #1;
    penable = 1'b1;
    #1;
    sb_check(32'(pready));
    sb_check(32'(pslverr));
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, input logic [7:0] exp_data, input logic exp_err);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = {8'h02, addr};
    sb_push($sformatf("rd%0h_data", addr), 32'(exp_data));
    sb_push($sformatf("rd%0h_err", addr), 32'(exp_err));
    @(posedge pclk); #1;
    penable = 1'b1;
    #1;
    sb_check(32'(prdata));
    sb_check(32'(pslverr));
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic check_irq(input string tag, input logic exp_out, input logic [2:0] exp_id);
    sb_push({tag, "_out"}, 32'(exp_out));
    sb_push({tag, "_id"}, 32'(exp_id));
    sb_check(32'(irq_out));
    sb_check(32'(irq_id));
  endtask

  initial begin
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; irq_src = '0;
    tick(3);
    presetn = 1'b1;
    tick(1);

    // 1: reset state
    check_irq("rst", 1'b0, 3'd0);
    for (int a = 0; a < 7; a++) apb_read(4'(a), 8'h00, 1'b0);
    apb_read(4'h9, 8'h00, 1'b1);

    // 2: edge capture on bit0, latency, W1C
    apb_write(4'h0, 8'h01, 1'b0);
    apb_write(4'h1, 8'h01, 1'b0);
    apb_write(4'h2, 8'h01, 1'b0);
    irq_src[0] = 1'b1;
    tick(3);
    check_irq("edge_e3", 1'b0, 3'd0);
    tick(1);
    check_irq("edge_e4", 1'b1, 3'd0);
    irq_src[0] = 1'b0;
    apb_read(4'h3, 8'h01, 1'b0);
    apb_write(4'h3, 8'h01, 1'b0);
    check_irq("w1c_hold", 1'b1, 3'd0);
    tick(1);
    check_irq("w1c_drop", 1'b0, 3'd0);

    // 3: level mode on bit2
    apb_write(4'h2, 8'h00, 1'b0);
    apb_write(4'h1, 8'h04, 1'b0);
    irq_src[2] = 1'b1;
    tick(5);
    apb_read(4'h3, 8'h04, 1'b0);
    apb_read(4'h5, 8'h82, 1'b0);
    apb_write(4'h3, 8'h04, 1'b0);
    apb_read(4'h3, 8'h04, 1'b0);
    irq_src[2] = 1'b0;
    tick(3);
    check_irq("lvl_fall3", 1'b1, 3'd2);
    tick(1);
    check_irq("lvl_fall4", 1'b0, 3'd0);
    apb_read(4'h3, 8'h00, 1'b0);
    apb_write(4'h6, 8'h04, 1'b0);
    apb_read(4'h3, 8'h00, 1'b0);

    // 4: level->edge switch, priority, masking, global enable
    irq_src[6] = 1'b1;
    tick(4);
    apb_read(4'h3, 8'h40, 1'b0);
    apb_write(4'h2, 8'hFF, 1'b0);
    apb_read(4'h3, 8'h00, 1'b0);
    apb_write(4'h1, 8'hFF, 1'b0);
    irq_src[5] = 1'b1;
    irq_src[3] = 1'b1;
    tick(5);
    check_irq("prio_3", 1'b1, 3'd3);
    apb_write(4'h3, 8'h08, 1'b0);
    tick(1);
    check_irq("prio_5", 1'b1, 3'd5);
    apb_read(4'h3, 8'h20, 1'b0);
    apb_write(4'h1, 8'h00, 1'b0);
    tick(1);
    check_irq("masked", 1'b0, 3'd0);
    apb_read(4'h3, 8'h20, 1'b0);
    apb_write(4'h1, 8'hFF, 1'b0);
    tick(1);
    check_irq("unmasked", 1'b1, 3'd5);
    apb_write(4'h0, 8'h00, 1'b0);
    tick(1);
    check_irq("gen_off", 1'b0, 3'd0);
    apb_write(4'h0, 8'h01, 1'b0);
    irq_src = '0;
    apb_write(4'h3, 8'hFF, 1'b0);
    tick(2);
    apb_read(4'h3, 8'h00, 1'b0);

    // 5: set beats W1C, ISWR, error decode
    apb_write(4'h6, 8'h02, 1'b0);
    apb_read(4'h3, 8'h02, 1'b0);
    irq_src[1] = 1'b1;
    apb_write(4'h3, 8'h02, 1'b0);
    apb_read(4'h3, 8'h02, 1'b0);
    apb_write(4'h3, 8'h02, 1'b0);
    apb_read(4'h3, 8'h00, 1'b0);
    apb_write(4'h6, 8'h80, 1'b0);
    tick(1);
    check_irq("iswr7", 1'b1, 3'd7);
    apb_read(4'h3, 8'h80, 1'b0);
    apb_read(4'h6, 8'h00, 1'b0);
    apb_read(4'h4, 8'h02, 1'b0);
    apb_write(4'h5, 8'hFF, 1'b1);
    apb_write(4'h4, 8'hFF, 1'b1);
    apb_write(4'hA, 8'hFF, 1'b1);
    apb_read(4'h3, 8'h80, 1'b0);
    irq_src[1] = 1'b0;

    // 6: timer trigger on bit0, then reset mid-write
    apb_write(4'h3, 8'h80, 1'b0);
    apb_write(4'h2, 8'h01, 1'b0);
    apb_write(4'h1, 8'h01, 1'b0);
    irq_src[0] = 1'b1;
    tick(2);
    irq_src[0] = 1'b0;
    tick(3);
    check_irq("trig", 1'b1, 3'd0);
    apb_read(4'h5, 8'h80, 1'b0);
    apb_write(4'h3, 8'h01, 1'b0);
    tick(1);
    check_irq("trig_clr", 1'b0, 3'd0);
    irq_src[0] = 1'b1;
    tick(2);
    irq_src[0] = 1'b0;
    tick(4);
    check_irq("trig2", 1'b1, 3'd0);

    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h021; pwdata = 8'hAA;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2;
    presetn = 1'b0;
    #1;
    sb_push("arst_rdy", 0);
    sb_check(32'(pready));
    sb_push("arst_err", 0);
    sb_check(32'(pslverr));
    sb_push("arst_prdata", 0);
    sb_check(32'(prdata));
    check_irq("arst", 1'b0, 3'd0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tick(1);
    presetn = 1'b1;
    apb_read(4'h1, 8'h00, 1'b0);
    apb_read(4'h0, 8'h00, 1'b0);
    apb_read(4'h3, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
